// File: rtl/serial_to_parallel_stream_if.sv
// Handshake bundles for serial_to_parallel_stream.
//
// s2p_serial_if   : beat stream into the packer
//   serial_valid  master->slave  beat present
//   serial_ready  slave->master  beat accepted when valid && ready
//   serial_data   master->slave  in_width-bit beat payload
//   flush         master->slave  single-cycle request to emit the partial word
//
// s2p_parallel_if : word stream out of the packer
//   parallel_valid    master->slave  word present
//   parallel_ready    slave->master  word consumed when valid && ready
//   parallel_data     master->slave  width-bit word payload
//   parallel_partial  master->slave  1 = word produced by flush
//   parallel_count    master->slave  number of valid bits in the word

interface s2p_serial_if #(
  parameter int in_width = 1
);
  logic                serial_valid;
  logic                serial_ready;
  logic [in_width-1:0] serial_data;
  logic                flush;

  modport master (output serial_valid, output serial_data, output flush,
                  input  serial_ready);
  modport slave  (input  serial_valid, input  serial_data, input  flush,
                  output serial_ready);
endinterface

interface s2p_parallel_if #(
  parameter int width = 8
);
  localparam int cw = $clog2(width) + 1;

  logic             parallel_valid;
  logic             parallel_ready;
  logic [width-1:0] parallel_data;
  logic             parallel_partial;
  logic [cw-1:0]    parallel_count;

  modport master (output parallel_valid, output parallel_data,
                  output parallel_partial, output parallel_count,
                  input  parallel_ready);
  modport slave  (input  parallel_valid, input  parallel_data,
                  input  parallel_partial, input  parallel_count,
                  output parallel_ready);
endinterface

// File: rtl/serial_to_parallel_stream.sv
// serial_to_parallel_stream: packs in_width-bit serial beats into width-bit
// words (LSB-first or MSB-first), with a registered, backpressure-capable
// output stage and a flush path that emits partially filled words.
//
// Ports:
//   clk  input   single clock, posedge
//   rst  input   synchronous reset, active-low
//   ser  s2p_serial_if.slave     beat input + flush request
//   par  s2p_parallel_if.master  word output with partial flag and bit count

module serial_to_parallel_stream #(
  parameter int width     = 8,
  parameter int in_width  = 1,
  parameter bit msb_first = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  s2p_serial_if.slave    ser,
  s2p_parallel_if.master par
);

  localparam int beats = width / in_width;
  localparam int cw    = $clog2(width) + 1;
  localparam int cntw  = $clog2(beats);
  localparam int fillw = cntw + 1;
  localparam logic [cntw-1:0] last_cnt = cntw'(beats - 1);

  logic [width-1:0] acc_q, acc_d;
  logic [cntw-1:0]  cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_partial_q, out_partial_d;
  logic [cw-1:0]    out_count_q, out_count_d;

  logic             out_free;
  logic             at_last;
  logic             ready;
  logic             accept;
  logic [fillw-1:0] fill_n;
  logic [width-1:0] acc_beat;
  logic [width-1:0] acc_now;

  assign out_free = !out_valid_q || par.parallel_ready;
  assign at_last  = (cnt_q == last_cnt);
  // The last beat of a word may only enter when the output slot frees up,
  // which makes serial_ready combinational on parallel_ready.
  assign ready    = !flush_pend_q && (!at_last || out_free);
  assign accept   = ser.serial_valid && ready;
  assign fill_n   = {1'b0, cnt_q} + fillw'(accept);

  assign ser.serial_ready     = ready;
  assign par.parallel_valid   = out_valid_q;
  assign par.parallel_data    = out_data_q;
  assign par.parallel_partial = out_partial_q;
  assign par.parallel_count   = out_count_q;

  // Accumulator contents with the current beat merged in. MSB-first shifts
  // left so partial words stay right-justified; LSB-first drops the beat at
  // its slot in an otherwise zeroed accumulator.
  always_comb begin
    if (msb_first) begin
      acc_beat = {acc_q[width-in_width-1:0], ser.serial_data};
    end else begin
      acc_beat = acc_q | (width'(ser.serial_data) << (int'(cnt_q) * in_width));
    end
    acc_now = accept ? acc_beat : acc_q;
  end

  always_comb begin
    acc_d         = acc_now;
    cnt_d         = fill_n[cntw-1:0];
    flush_pend_d  = flush_pend_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;
    out_count_d   = out_count_q;

    if (out_valid_q && par.parallel_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && at_last) begin
      // Full word; a coincident flush has nothing left to emit.
      out_valid_d   = 1'b1;
      out_data_d    = acc_beat;
      out_partial_d = 1'b0;
      out_count_d   = cw'(width);
      acc_d         = '0;
      cnt_d         = '0;
    end else if (flush_pend_q) begin
      // No beats enter while pending, so acc_q/cnt_q are the flushed word.
      if (out_free) begin
        out_valid_d   = 1'b1;
        out_data_d    = acc_q;
        out_partial_d = 1'b1;
        out_count_d   = cw'(int'(cnt_q) * in_width);
        acc_d         = '0;
        cnt_d         = '0;
        flush_pend_d  = 1'b0;
      end
    end else if (ser.flush && (fill_n != '0)) begin
      if (out_free) begin
        out_valid_d   = 1'b1;
        out_data_d    = acc_now;
        out_partial_d = 1'b1;
        out_count_d   = cw'(int'(fill_n) * in_width);
        acc_d         = '0;
        cnt_d         = '0;
      end else begin
        flush_pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      flush_pend_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
      out_count_q   <= '0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_partial_q <= out_partial_d;
      out_count_q   <= out_count_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Bench for serial_to_parallel_stream: three instances (LSB-first x1,
// MSB-first x1, LSB-first x2) share valid/flush/ready stimulus. A word-level
// reference model predicts every emitted word; directed tasks check timing.

module tb_serial_to_parallel_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv, fl, pr;
  logic       d1;
  logic [1:0] d2;
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  s2p_serial_if #(.in_width(1)) sif0 ();
  s2p_serial_if #(.in_width(1)) sif1 ();
  s2p_serial_if #(.in_width(2)) sif2 ();
  s2p_parallel_if #(.width(8))  pif0 ();
  s2p_parallel_if #(.width(8))  pif1 ();
  s2p_parallel_if #(.width(8))  pif2 ();

  assign sif0.serial_valid = sv;  assign sif0.serial_data = d1;  assign sif0.flush = fl;
  assign sif1.serial_valid = sv;  assign sif1.serial_data = d1;  assign sif1.flush = fl;
  assign sif2.serial_valid = sv;  assign sif2.serial_data = d2;  assign sif2.flush = fl;
  assign pif0.parallel_ready = pr;
  assign pif1.parallel_ready = pr;
  assign pif2.parallel_ready = pr;

  serial_to_parallel_stream #(.width(8), .in_width(1), .msb_first(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ser(sif0), .par(pif0));
  serial_to_parallel_stream #(.width(8), .in_width(1), .msb_first(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ser(sif1), .par(pif1));
  serial_to_parallel_stream #(.width(8), .in_width(2), .msb_first(1'b0)) dut2 (
    .clk(clk), .rst(rst), .ser(sif2), .par(pif2));

  logic       sr [3];
  logic       pv [3];
  logic [7:0] pd [3];
  logic       pp [3];
  logic [3:0] pc [3];

  assign sr[0] = sif0.serial_ready;    assign sr[1] = sif1.serial_ready;    assign sr[2] = sif2.serial_ready;
  assign pv[0] = pif0.parallel_valid;  assign pv[1] = pif1.parallel_valid;  assign pv[2] = pif2.parallel_valid;
  assign pd[0] = pif0.parallel_data;   assign pd[1] = pif1.parallel_data;   assign pd[2] = pif2.parallel_data;
  assign pp[0] = pif0.parallel_partial; assign pp[1] = pif1.parallel_partial; assign pp[2] = pif2.parallel_partial;
  assign pc[0] = pif0.parallel_count;  assign pc[1] = pif1.parallel_count;  assign pc[2] = pif2.parallel_count;

  // Reference model: beats collected per instance, expected words in a ring.
  int         hist [3][8];
  int         nf   [3];
  int         ed   [3][64];
  int         ep   [3][64];
  int         ec   [3][64];
  int         hd   [3];
  int         tl   [3];
  logic       hold [3];
  logic [7:0] hdat [3];
  logic       hpar [3];
  logic [3:0] hcnt [3];

  function automatic int iw_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Beat k of n goes to bit k*iw (LSB-first) or (n-1-k)*iw (MSB-first).
  function automatic int mkword(input int i, input int n);
    int w = 0;
    int pos;
    for (int k = 0; k < n; k++) begin
      pos = (i == 1) ? (n - 1 - k) * iw_of(i) : k * iw_of(i);
      w += hist[i][k] << pos;
    end
    return w;
  endfunction

  task automatic push_word(input int i);
    ed[i][tl[i]] = mkword(i, nf[i]);
    ep[i][tl[i]] = (nf[i] != 8 / iw_of(i)) ? 1 : 0;
    ec[i][tl[i]] = nf[i] * iw_of(i);
    tl[i] = (tl[i] + 1) % 64;
    nf[i] = 0;
  endtask

  // Observes the cycle just before the coming posedge.
  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        nf[i] = 0; hd[i] = tl[i]; hold[i] = 1'b0;
        continue;
      end
      if (hold[i]) begin
        vectors++;
        if (pv[i] !== 1'b1 || pd[i] !== hdat[i] || pp[i] !== hpar[i] || pc[i] !== hcnt[i]) begin
          errors++;
          $display("FAIL hold_stable dut%0d: got v=%0b d=%h p=%0b c=%0d, need v=1 d=%h p=%0b c=%0d",
                   i, pv[i], pd[i], pp[i], pc[i], hdat[i], hpar[i], hcnt[i]);
        end
      end
      hold[i] = pv[i] && !pr;
      hdat[i] = pd[i]; hpar[i] = pp[i]; hcnt[i] = pc[i];
      if (pv[i] && pr) begin
        vectors++;
        if (hd[i] == tl[i]) begin
          errors++;
          $display("FAIL unexpected_word dut%0d: got d=%h, need no word", i, pd[i]);
        end else begin
          if (pd[i] !== 8'(ed[i][hd[i]]) || pp[i] !== (ep[i][hd[i]] != 0) || pc[i] !== 4'(ec[i][hd[i]])) begin
            errors++;
            $display("FAIL word dut%0d: got d=%h p=%0b c=%0d, need d=%h p=%0b c=%0d",
                     i, pd[i], pp[i], pc[i], 8'(ed[i][hd[i]]), ep[i][hd[i]], ec[i][hd[i]]);
          end
          hd[i] = (hd[i] + 1) % 64;
        end
      end
      if (sv && sr[i]) begin
        hist[i][nf[i]] = (i == 2) ? int'(d2) : int'(d1);
        nf[i]++;
      end
      if (nf[i] == 8 / iw_of(i)) push_word(i);
      else if (fl && nf[i] > 0) push_word(i);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic b, input logic f);
    sv = v; d1 = b; d2 = 2'($urandom_range(0, 3)); fl = f;
    tick();
  endtask

  task automatic cyc2(input logic v, input logic [1:0] b2, input logic f);
    sv = v; d1 = 1'($urandom_range(0, 1)); d2 = b2; fl = f;
    tick();
  endtask

  task automatic align();
    pr = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; sv = 1'b0; fl = 1'b0; pr = 1'b0; d1 = 1'b0; d2 = 2'd0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pv[i] !== 1'b0 || pd[i] !== 8'h00 || pp[i] !== 1'b0 || pc[i] !== 4'd0 || sr[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: got v=%0b d=%h p=%0b c=%0d sr=%0b, need 0/00/0/0 sr=1",
                 i, pv[i], pd[i], pp[i], pc[i], sr[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_lsb_msb();
    logic [7:0] pat;
    pat = 8'h4D;
    pr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, pat[k], 1'b0);
      if (k == 6) begin
        vectors++;
        if (pv[0] !== 1'b0) begin
          errors++;
          $display("FAIL early_word: got v=%0b, need 0", pv[0]);
        end
      end
    end
    vectors++;
    if (pv[0] !== 1'b1 || pd[0] !== 8'h4D || pc[0] !== 4'd8 || pp[0] !== 1'b0) begin
      errors++;
      $display("FAIL lsb_word: got v=%0b d=%h c=%0d p=%0b, need 1/4d/8/0", pv[0], pd[0], pc[0], pp[0]);
    end
    vectors++;
    if (pv[1] !== 1'b1 || pd[1] !== 8'hB2 || pc[1] !== 4'd8 || pp[1] !== 1'b0) begin
      errors++;
      $display("FAIL msb_word: got v=%0b d=%h c=%0d p=%0b, need 1/b2/8/0", pv[1], pd[1], pc[1], pp[1]);
    end
    cyc(1'b0, 1'b0, 1'b0);
    vectors++;
    if (pv[0] !== 1'b0 || pv[1] !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle: got v0=%0b v1=%0b, need 0/0", pv[0], pv[1]);
    end
  endtask

  task automatic test_in_width2();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00;
    align();
    for (int k = 0; k < 4; k++) cyc2(1'b1, seq[k], 1'b0);
    vectors++;
    if (pv[2] !== 1'b1 || pd[2] !== 8'h39 || pc[2] !== 4'd8 || pp[2] !== 1'b0) begin
      errors++;
      $display("FAIL w2_word: got v=%0b d=%h c=%0d p=%0b, need 1/39/8/0", pv[2], pd[2], pc[2], pp[2]);
    end
    sv = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] rnd, rev;
    align();
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    vectors++;
    if (pv[0] !== 1'b1 || pd[0] !== 8'h03 || pc[0] !== 4'd3 || pp[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_lsb: got v=%0b d=%h c=%0d p=%0b, need 1/03/3/1", pv[0], pd[0], pc[0], pp[0]);
    end
    vectors++;
    if (pv[1] !== 1'b1 || pd[1] !== 8'h06 || pc[1] !== 4'd3 || pp[1] !== 1'b1) begin
      errors++;
      $display("FAIL flush_msb: got v=%0b d=%h c=%0d p=%0b, need 1/06/3/1", pv[1], pd[1], pc[1], pp[1]);
    end
    // flush together with a beat: that beat is part of the partial word
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b1);
    vectors++;
    if (pd[0] !== 8'h01 || pd[1] !== 8'h02 || pc[0] !== 4'd2 || pp[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle: got d0=%h d1=%h c=%0d p=%0b, need 01/02/2/1", pd[0], pd[1], pc[0], pp[0]);
    end
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    vectors++;
    if (pv[0] !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush: got v=%0b, need 0", pv[0]);
    end
    rnd = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      rev[7-k] = rnd[k];
      cyc(1'b1, rnd[k], 1'b0);
    end
    vectors++;
    if (pv[0] !== 1'b1 || pd[0] !== rnd || pd[1] !== rev || pp[0] !== 1'b0 || pc[0] !== 4'd8) begin
      errors++;
      $display("FAIL after_flush_word: got d0=%h d1=%h p=%0b c=%0d, need %h/%h/0/8", pd[0], pd[1], pp[0], pc[0], rnd, rev);
    end
    sv = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    align();
    pr = 1'b0;
    w = 16'($urandom);
    for (int k = 0; k < 15; k++) cyc(1'b1, w[k], 1'b0);
    sv = 1'b1; d1 = w[15];
    vectors++;
    if (sr[0] !== 1'b0 || pv[0] !== 1'b1 || pd[0] !== w[7:0]) begin
      errors++;
      $display("FAIL bp_stall: got sr=%0b v=%0b d=%h, need 0/1/%h", sr[0], pv[0], pd[0], w[7:0]);
    end
    for (int k = 0; k < 3; k++) tick();
    vectors++;
    if (sr[0] !== 1'b0 || pd[0] !== w[7:0]) begin
      errors++;
      $display("FAIL bp_held: got sr=%0b d=%h, need 0/%h", sr[0], pd[0], w[7:0]);
    end
    pr = 1'b1;
    #1;
    vectors++;
    if (sr[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb: got sr=%0b, need 1", sr[0]);
    end
    tick();
    sv = 1'b0;
    vectors++;
    if (pv[0] !== 1'b1 || pd[0] !== w[15:8]) begin
      errors++;
      $display("FAIL bp_second: got v=%0b d=%h, need 1/%h", pv[0], pd[0], w[15:8]);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_stalled();
    logic [7:0] w, p;
    align();
    pr = 1'b0;
    w = 8'($urandom);
    p = 8'($urandom) & 8'h1F;
    for (int k = 0; k < 8; k++) cyc(1'b1, w[k], 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, p[k], 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    vectors++;
    if (sr[0] !== 1'b0 || pv[0] !== 1'b1 || pd[0] !== w) begin
      errors++;
      $display("FAIL fs_pending: got sr=%0b v=%0b d=%h, need 0/1/%h", sr[0], pv[0], pd[0], w);
    end
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    pr = 1'b1;
    sv = 1'b1;
    #1;
    vectors++;
    if (sr[0] !== 1'b0) begin
      errors++;
      $display("FAIL fs_hold_ready: got sr=%0b, need 0", sr[0]);
    end
    tick();
    sv = 1'b0;
    vectors++;
    if (pv[0] !== 1'b1 || pp[0] !== 1'b1 || pc[0] !== 4'd5 || pd[0] !== p || sr[0] !== 1'b1) begin
      errors++;
      $display("FAIL fs_partial: got v=%0b p=%0b c=%0d d=%h sr=%0b, need 1/1/5/%h/1", pv[0], pp[0], pc[0], pd[0], sr[0], p);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midword();
    logic [7:0] rnd, rev;
    align();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pv[i] !== 1'b0 || pd[i] !== 8'h00 || pp[i] !== 1'b0 || pc[i] !== 4'd0 || sr[i] !== 1'b1) begin
        errors++;
        $display("FAIL midword_reset dut%0d: got v=%0b d=%h p=%0b c=%0d sr=%0b, need 0/00/0/0/1",
                 i, pv[i], pd[i], pp[i], pc[i], sr[i]);
      end
    end
    rst = 1'b1;
    rnd = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      rev[7-k] = rnd[k];
      cyc(1'b1, rnd[k], 1'b0);
    end
    vectors++;
    if (pv[0] !== 1'b1 || pd[0] !== rnd || pd[1] !== rev || pc[0] !== 4'd8) begin
      errors++;
      $display("FAIL post_reset_word: got v=%0b d0=%h d1=%h c=%0d, need 1/%h/%h/8", pv[0], pd[0], pd[1], pc[0], rnd, rev);
    end
    sv = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      sv = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 15) == 0);
      d1 = 1'($urandom_range(0, 1));
      d2 = 2'($urandom_range(0, 3));
      tick();
    end
    sv = 1'b0; fl = 1'b0; pr = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (hd[i] != tl[i]) begin
        errors++;
        $display("FAIL words_missing dut%0d: got %0d outstanding, need 0", i, (tl[i] - hd[i] + 64) % 64);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nf[i] = 0; hd[i] = 0; tl[i] = 0; hold[i] = 1'b0;
    end
    test_reset();
    test_lsb_msb();
    test_in_width2();
    test_flush();
    test_backpressure();
    test_flush_stalled();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
